// File: rtl/spi_master_tx_shifter.sv
// spi_master_tx_shifter: FIFO-fed SPI TX serialiser, MSB-first; quad lanes available when SPI_TX_QUAD_EN is defined.
module spi_master_tx_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  bits_i,
  input  logic                  quad_i,
  input  logic [7:0]            clk_div_i,
  input  logic                  cpol_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sclk_o,
  output logic [3:0]            sdo_o,
  output logic                  oe_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int WLW = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, SHIFT, DONE} state_e;
  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d, rem_nx, step;
  logic [WLW-1:0]        wl_q, wl_d, wl_nx, wl_init;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [7:0]            div_q, div_d, cnt_q, cnt_d;
  logic                  phase_q, phase_d, tc;
`ifdef SPI_TX_QUAD_EN
  logic quad_q, quad_d;
  assign quad_d  = (state_q == IDLE && start_i && bits_i != '0) ? quad_i : quad_q;
  assign step    = quad_q ? CNT_WIDTH'(4) : CNT_WIDTH'(1);
  assign wl_init = quad_q ? WLW'(DATA_WIDTH / 4) : WLW'(DATA_WIDTH);
  assign sdo_o   = (state_q == IDLE) ? 4'h0 :
                   quad_q ? sh_q[DATA_WIDTH-1 -: 4] : {3'b000, sh_q[DATA_WIDTH-1]};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) quad_q <= 1'b0;
    else         quad_q <= quad_d;
  end
`else
  logic unused_quad;
  assign unused_quad = quad_i;
  assign step        = CNT_WIDTH'(1);
  assign wl_init     = WLW'(DATA_WIDTH);
  assign sdo_o       = {3'b000, state_q != IDLE && sh_q[DATA_WIDTH-1]};
`endif
  assign tc     = cnt_q == div_q;
  assign rem_nx = (rem_q <= step) ? '0 : rem_q - step;
  assign wl_nx  = wl_q - 1'b1;
  // The shift is skipped on a word's final edge so sdo_o keeps the last bit while refilling.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wl_d    = wl_q;
    sh_d    = sh_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      state_d = IDLE;
      rem_d   = '0;
      wl_d    = '0;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i && bits_i != '0) begin
          state_d = WAIT_DATA;
          rem_d   = bits_i;
          div_d   = clk_div_i;
          sh_d    = '0;
        end
        WAIT_DATA: if (valid_i) begin
          state_d = SHIFT;
          sh_d    = data_i;
          wl_d    = wl_init;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
        SHIFT: begin
          cnt_d   = tc ? 8'd0 : cnt_q + 8'd1;
          phase_d = phase_q ^ tc;
          if (tc && phase_q) begin
            rem_d   = rem_nx;
            wl_d    = wl_nx;
            state_d = (rem_nx == '0) ? DONE : (wl_nx == '0) ? WAIT_DATA : SHIFT;
            sh_d    = (rem_nx != '0 && wl_nx != '0) ? sh_q << step : sh_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wl_q    <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wl_q    <= wl_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign ready_o = state_q == WAIT_DATA && !clr_i;
  assign sclk_o  = cpol_i ^ phase_q;
  assign oe_o    = state_q == WAIT_DATA || state_q == SHIFT;
  assign busy_o  = state_q != IDLE;
  assign done_o  = state_q == DONE && !clr_i;
endmodule

// File: tb/tb_spi_master_tx_shifter.sv
// tb_spi_master_tx_shifter: vector table, corner sequences and randomized transfers against a transaction-level model.
module tb_spi_master_tx_shifter;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef SPI_TX_QUAD_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  logic          clk_i = 1'b0, rst_ni = 1'b0, clr_i = 1'b0, start_i = 1'b0;
  logic          quad_i = 1'b0, cpol_i = 1'b0, valid_i = 1'b0;
  logic [CW-1:0] bits_i = '0;
  logic [7:0]    clk_div_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o, sclk_o, oe_o, busy_o, done_o;
  logic [3:0]    sdo_o;

  spi_master_tx_shifter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .start_i(start_i), .bits_i(bits_i),
    .quad_i(quad_i), .clk_div_i(clk_div_i), .cpol_i(cpol_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .sclk_o(sclk_o), .sdo_o(sdo_o), .oe_o(oe_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [3:0] caps[$];
  int pops, dones, done_cyc, glitches;
  logic prev_sclk = 1'b0, hs = 1'b0, rdy_s = 1'b0;
  logic [3:0] prev_sdo = '0;

  always @(negedge clk_i) begin
    if (busy_o && sclk_o != prev_sclk && sclk_o != cpol_i) caps.push_back(sdo_o);
    if (sclk_o != cpol_i && prev_sclk != cpol_i && sdo_o != prev_sdo) glitches++;
    if (ready_o && valid_i) pops++;
    if (done_o) begin
      dones++;
      done_cyc = cyc;
    end
    hs        = ready_o && valid_i;
    rdy_s     = ready_o;
    prev_sclk = sclk_o;
    prev_sdo  = sdo_o;
  end

  logic [DW-1:0] words[4];
  int nw, lag, widx, waitcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (hs) begin
      widx++;
      waitcnt = 0;
    end else if (rdy_s && !valid_i) waitcnt++;
    #1;
    data_i  = words[widx < 4 ? widx : 0];
    valid_i = (widx < nw) && (widx == 0 || waitcnt >= lag);
  endtask

  task automatic clear_mon(input int n, input int lg);
    nw = n; lag = lg; widx = 0; waitcnt = 0;
    caps.delete();
    pops = 0; dones = 0; glitches = 0; done_cyc = -1;
  endtask

  task automatic run(input int bits, input bit q, input int div, input bit cp, input int lg,
                     input int poke, output int t0);
    int units, upw;
    units = (q && QEN) ? (bits + 3) / 4 : bits;
    upw   = (q && QEN) ? DW / 4 : DW;
    clear_mon((units + upw - 1) / upw, lg);
    cpol_i = cp; data_i = words[0]; valid_i = 1'b1;
    bits_i = CW'(bits); quad_i = q; clk_div_i = 8'(div); start_i = 1'b1;
    t0 = cyc;
    tick();
    start_i = 1'b0;
    for (int k = 1; k < 3000 && dones == 0; k++) begin
      if (k == poke) begin
        start_i = 1'b1;
        bits_i  = CW'(100);
      end
      tick();
      start_i = 1'b0;
    end
    tick();
    tick();
  endtask

  function automatic logic [63:0] stream_of(input bit q);
    logic [63:0] s = '0;
    foreach (caps[i]) s = (q && QEN) ? (s << 4) | 64'(caps[i]) : (s << 1) | 64'(caps[i][0]);
    return s;
  endfunction

  typedef struct {
    int bits; bit q; int div; bit cp; int lag; int poke;
    logic [31:0] w0; logic [31:0] w1;
    int ncap; logic [63:0] stream; int npops; int doff;
  } vec_t;
  vec_t v[8];

  initial begin
    int t0;
    v[0] = '{8, 1'b0, 0, 1'b0, 0, 0, 32'hA500_0000, 32'h0, 8, 64'hA5, 1, 18};
    v[1] = '{40, 1'b0, 0, 1'b0, 5, 0, 32'hFFFF_FFFF, 32'h0, 40, 64'hFF_FFFF_FF00, 2, 88};
    v[2] = '{12, 1'b0, 2, 1'b1, 0, 0, 32'h5A3C_0000, 32'h0, 12, 64'h5A3, 1, 74};
    v[3] = QEN ? '{32, 1'b1, 1, 1'b0, 0, 0, 32'h1234_5678, 32'h0, 8, 64'h1234_5678, 1, 34}
               : '{32, 1'b1, 1, 1'b0, 0, 0, 32'h1234_5678, 32'h0, 32, 64'h1234_5678, 1, 130};
    v[4] = '{5, 1'b0, 0, 1'b0, 0, 0, 32'hF800_0000, 32'h0, 5, 64'h1F, 1, 12};
    v[5] = QEN ? '{6, 1'b1, 0, 1'b1, 0, 0, 32'hAB00_0000, 32'h0, 2, 64'hAB, 1, 6}
               : '{6, 1'b1, 0, 1'b1, 0, 0, 32'hAB00_0000, 32'h0, 6, 64'h2A, 1, 14};
    v[6] = '{8, 1'b0, 0, 1'b0, 0, 6, 32'hA500_0000, 32'h0, 8, 64'hA5, 1, 18};
    v[7] = '{36, 1'b0, 1, 1'b0, 0, 0, 32'h0F0F_0F0F, 32'hC000_0000, 36, 64'h0_F0F0_F0FC, 2, 147};
    clear_mon(0, 0);
    tick();
    chk("reset_outputs", {ready_o, oe_o, busy_o, done_o, sdo_o}, '0);
    chk("reset_sclk", sclk_o, cpol_i);
    tick();
    rst_ni = 1'b1;
    tick();

    foreach (v[i]) begin
      words[0] = v[i].w0; words[1] = v[i].w1; words[2] = '0; words[3] = '0;
      run(v[i].bits, v[i].q, v[i].div, v[i].cp, v[i].lag, v[i].poke, t0);
      chk($sformatf("vec%0d_ncap", i), caps.size(), v[i].ncap);
      chk($sformatf("vec%0d_stream", i), stream_of(v[i].q), v[i].stream);
      chk($sformatf("vec%0d_pops", i), pops, v[i].npops);
      chk($sformatf("vec%0d_dones", i), dones, 1);
      chk($sformatf("vec%0d_done_cycle", i), done_cyc - t0, v[i].doff);
      chk($sformatf("vec%0d_stable", i), glitches, 0);
      chk($sformatf("vec%0d_idle", i), {busy_o, oe_o, sdo_o}, '0);
    end

    clear_mon(1, 0);
    bits_i = '0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("zero_bits_busy", busy_o, 1'b0);
    tick();
    chk("zero_bits_busy2", {busy_o, ready_o}, '0);

    // abort in WAIT_DATA with data on offer: no pop may happen
    foreach (words[i]) words[i] = $urandom;
    clear_mon(4, 0);
    cpol_i = 1'b1; valid_i = 1'b1; bits_i = CW'(100); clk_div_i = 8'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0; clr_i = 1'b1;
    #3;
    chk("abort_wait_ready", ready_o, 1'b0);
    tick();
    clr_i = 1'b0;
    chk("abort_wait_busy", busy_o, 1'b0);
    repeat (3) tick();
    chk("abort_wait_pops", pops, 0);

    clear_mon(4, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    clr_i = 1'b1;
    #3;
    chk("abort_shift_ready", ready_o, 1'b0);
    tick();
    clr_i = 1'b0;
    chk("abort_shift_state", {busy_o, done_o, oe_o}, '0);
    chk("abort_shift_sclk", sclk_o, 1'b1);
    repeat (5) tick();
    chk("abort_shift_dones", dones, 0);
    chk("abort_shift_pops", pops, 1);

    clear_mon(4, 0);
    cpol_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_outputs", {ready_o, oe_o, busy_o, done_o, sdo_o}, '0);
    chk("async_rst_sclk", sclk_o, cpol_i);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("after_rst_idle", {ready_o, oe_o, busy_o, done_o, sdo_o}, '0);

    for (int t = 0; t < 20; t++) begin
      int bits, div, lg, units, upw, bad, eoff;
      bit q, cp, eq;
      logic [31:0] w;
      logic [3:0] e;
      bits = $urandom_range(1, 100); q = 1'($urandom_range(0, 1));
      div = $urandom_range(0, 3); cp = 1'($urandom_range(0, 1)); lg = $urandom_range(0, 3);
      foreach (words[i]) words[i] = $urandom;
      eq    = q && QEN;
      units = eq ? (bits + 3) / 4 : bits;
      upw   = eq ? DW / 4 : DW;
      run(bits, q, div, cp, lg, 0, t0);
      bad = (caps.size() == units) ? 0 : 1;
      for (int i = 0; i < units && i < caps.size(); i++) begin
        w = words[i / upw];
        e = eq ? w[31 - 4 * (i % upw) -: 4] : {3'b000, w[31 - (i % upw)]};
        if (caps[i] !== e) bad++;
      end
      eoff = 1 + lg * (nw - 1);
      for (int k = 0; k < nw; k++)
        eoff += 1 + ((k == nw - 1) ? units - upw * (nw - 1) : upw) * 2 * (div + 1);
      chk($sformatf("rand%0d_data bits=%0d q=%0d", t, bits, q), bad, 0);
      chk($sformatf("rand%0d_pops", t), pops, nw);
      chk($sformatf("rand%0d_dones", t), dones, 1);
      chk($sformatf("rand%0d_done_cycle", t), done_cyc - t0, eoff);
      chk($sformatf("rand%0d_stable", t), glitches, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
